// File: rtl/usart_seq_pkg.sv
// usart_seq_pkg: USARTn register map, UCSRnA bit positions and sequencer states.
package usart_seq_pkg;
  localparam logic [11:0] UCSRnA = 12'h0C0;
  localparam logic [11:0] UCSRnB = 12'h0C1;
  localparam logic [11:0] UCSRnC = 12'h0C2;
  localparam logic [11:0] UBRRnL = 12'h0C4;
  localparam logic [11:0] UBRRnH = 12'h0C5;
  localparam logic [11:0] UDRn   = 12'h0C6;
  localparam int RXC  = 7;
  localparam int UDRE = 5;
  localparam int FE   = 4;
  localparam int DOR  = 3;
  localparam int UPE  = 2;
  localparam int U2X  = 1;
  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_POLL, S_PGAP, S_DECIDE, S_RD, S_WR, S_GAP, S_SHUT, S_SGAP
  } seq_state_t;
endpackage

// File: rtl/usart_bus_sequencer.sv
// usart_bus_sequencer: configures one USARTn, then polls it to drain RX bytes and feed TX bytes.
// Define USEQ_RX_ERR_EN to capture {FEn,DORn,UPEn} into rx_err; otherwise rx_err is tied to 0.
module usart_bus_sequencer #(
  parameter logic [11:0] UBRR_VAL  = 12'd129,
  parameter logic [7:0]  UCSRC_VAL = 8'h06,
  parameter logic [7:0]  UCSRB_VAL = 8'h18,
  parameter logic        U2X_VAL   = 1'b0
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        start,
  input  logic        stop,
  output logic        cfg_done,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [2:0]  rx_err,
  output logic [11:0] ram_Addr,
  output logic        ramre,
  output logic        ramwe,
  output logic [7:0]  dbus_out,
  input  logic [7:0]  dbus_in
);
  import usart_seq_pkg::*;
  seq_state_t r_state;
  logic [3:0] r_cnt;
  logic       r_rxc;
  logic       r_udre;
  logic [2:0]  w_idx;
  logic        w_cfg_wr;
  logic [11:0] w_cfg_addr;
  logic [7:0]  w_cfg_data;
  // Config cycles alternate write/gap; r_cnt is the index of the cycle being issued.
  assign w_idx      = r_cnt[3:1];
  assign w_cfg_wr   = ~r_cnt[0];
  assign w_cfg_addr = w_idx == 3'd0 ? UBRRnH : w_idx == 3'd1 ? UBRRnL :
                      w_idx == 3'd2 ? UCSRnA : w_idx == 3'd3 ? UCSRnC : UCSRnB;
  assign w_cfg_data = w_idx == 3'd0 ? {4'h0, UBRR_VAL[11:8]} : w_idx == 3'd1 ? UBRR_VAL[7:0] :
                      w_idx == 3'd2 ? {6'b0, U2X_VAL, 1'b0} : w_idx == 3'd3 ? UCSRC_VAL : UCSRB_VAL;
  assign tx_ready = r_state == S_DECIDE && !stop && !r_rxc && r_udre && tx_valid;
`ifdef USEQ_RX_ERR_EN
  logic [2:0] r_err;
`else
  assign rx_err = 3'b000;
`endif
  always_ff @(posedge cp2) begin
    if (!ireset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rxc    <= 1'b0;
      r_udre   <= 1'b0;
      cfg_done <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ram_Addr <= '0;
      ramre    <= 1'b0;
      ramwe    <= 1'b0;
      dbus_out <= '0;
`ifdef USEQ_RX_ERR_EN
      r_err    <= '0;
      rx_err   <= '0;
`endif
    end else begin
      ramre    <= 1'b0;
      ramwe    <= 1'b0;
      ram_Addr <= '0;
      dbus_out <= '0;
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start && !stop) begin
          ramwe    <= 1'b1;
          ram_Addr <= w_cfg_addr;
          dbus_out <= w_cfg_data;
          r_cnt    <= 4'd1;
          r_state  <= S_CFG;
        end
        S_CFG: if (r_cnt == 4'd10) begin
          cfg_done <= 1'b1;
          r_cnt    <= '0;
          ramre    <= 1'b1;
          ram_Addr <= UCSRnA;
          r_state  <= S_POLL;
        end else begin
          ramwe    <= w_cfg_wr;
          ram_Addr <= w_cfg_wr ? w_cfg_addr : 12'h000;
          dbus_out <= w_cfg_wr ? w_cfg_data : 8'h00;
          r_cnt    <= r_cnt + 4'd1;
        end
        S_POLL: begin
          r_rxc   <= dbus_in[RXC];
          r_udre  <= dbus_in[UDRE];
`ifdef USEQ_RX_ERR_EN
          r_err   <= dbus_in[FE:UPE];
`endif
          r_state <= S_PGAP;
        end
        S_PGAP: r_state <= S_DECIDE;
        // dbus_out doubles as the TX holding register for the UDRn write cycle.
        S_DECIDE: if (stop) begin
          ramwe    <= 1'b1;
          ram_Addr <= UCSRnB;
          r_state  <= S_SHUT;
        end else if (r_rxc) begin
          ramre    <= 1'b1;
          ram_Addr <= UDRn;
          r_state  <= S_RD;
        end else if (r_udre && tx_valid) begin
          ramwe    <= 1'b1;
          ram_Addr <= UDRn;
          dbus_out <= tx_data;
          r_state  <= S_WR;
        end else begin
          ramre    <= 1'b1;
          ram_Addr <= UCSRnA;
          r_state  <= S_POLL;
        end
        S_RD: begin
          rx_data  <= dbus_in;
          rx_valid <= 1'b1;
`ifdef USEQ_RX_ERR_EN
          rx_err   <= r_err;
`endif
          r_state  <= S_GAP;
        end
        S_WR: r_state <= S_GAP;
        S_GAP: begin
          ramre    <= 1'b1;
          ram_Addr <= UCSRnA;
          r_state  <= S_POLL;
        end
        S_SHUT: r_state <= S_SGAP;
        S_SGAP: begin
          cfg_done <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
